// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (8N1 frame decoder) feeding a first-word-fall-through receive FIFO.
// Optional macro UART_RX_PARITY_EN switches the frame to 8E1 and enables the sticky parity flag.
module uart_rx_fifo #(
   parameter int CLOCK_FREQUENCY_HZ = 50000000,
   parameter int BAUD_RATE          = 115200,
   parameter int FIFO_DEPTH         = 8
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       uart_rx,
   input  logic       read_enable,
   output logic [7:0] read_data,
   output logic       data_valid,
   output logic       fifo_full,
   output logic       framing_error,
   output logic       overrun_error,
   output logic       parity_error,
   input  logic       clear_errors
);

   localparam int CYCLES_PER_BIT = CLOCK_FREQUENCY_HZ / BAUD_RATE;
   localparam int HALF           = CYCLES_PER_BIT / 2;
   localparam int CNT_W          = $clog2(CYCLES_PER_BIT) + 1;
   localparam int PTR_W          = $clog2(FIFO_DEPTH);
   localparam int BIT_LOAD_I     = CYCLES_PER_BIT - 1;
   localparam int HALF_LOAD_I    = HALF - 1;

   localparam logic [CNT_W-1:0] BIT_LOAD  = BIT_LOAD_I[CNT_W-1:0];
   localparam logic [CNT_W-1:0] HALF_LOAD = HALF_LOAD_I[CNT_W-1:0];
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W:0]   CNT1_ONE  = {{PTR_W{1'b0}}, 1'b1};
   localparam logic [PTR_W:0]   DEPTH_CNT = FIFO_DEPTH[PTR_W:0];

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   logic             r_sync1;
   logic             r_sync2;
   logic             r_prev;
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic [7:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             r_valid;
   logic             r_full;
   logic             r_framing_error;
   logic             r_overrun_error;

   logic             w_start_edge;
   logic             w_tick;
   logic             w_stop_sample;
   logic             w_frame_ok;
   logic             w_framing_set;
   logic             w_overrun_set;
   logic             w_push;
   logic             w_pop;
   logic [PTR_W:0]   w_count_nxt;

`ifdef UART_RX_PARITY_EN
   logic             r_par_bad;
   logic             r_parity_error;
   logic             w_parity_set;
`endif

   // Two-flop synchronizer plus a delayed copy used for start-edge detection.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
      end else begin
         r_sync1 <= uart_rx;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_start_edge  = r_prev & ~r_sync2;
   assign w_tick        = (r_cnt == {CNT_W{1'b0}});
   assign w_stop_sample = (r_state == ST_STOP) & w_tick;
   assign w_framing_set = w_stop_sample & ~r_sync2;
`ifdef UART_RX_PARITY_EN
   assign w_frame_ok    = w_stop_sample & r_sync2 & ~r_par_bad;
   assign w_parity_set  = w_stop_sample & r_par_bad;
`else
   assign w_frame_ok    = w_stop_sample & r_sync2;
`endif

   // Frame decoder: counter reloads on every sample, so each state waits a full bit period.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= {CNT_W{1'b0}};
         r_bit_idx <= 3'd0;
         r_shift   <= 8'h00;
`ifdef UART_RX_PARITY_EN
         r_par_bad <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start_edge) begin
                  r_cnt   <= HALF_LOAD;
                  r_state <= ST_START;
               end
            end
            ST_START: begin
               if (w_tick) begin
                  if (r_sync2) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_cnt     <= BIT_LOAD;
                     r_bit_idx <= 3'd0;
                     r_state   <= ST_DATA;
                  end
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            ST_DATA: begin
               if (w_tick) begin
                  r_shift <= {r_sync2, r_shift[7:1]};
                  r_cnt   <= BIT_LOAD;
                  if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     r_state <= ST_PARITY;
`else
                     r_state <= ST_STOP;
`endif
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                  end
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (w_tick) begin
                  r_par_bad <= (^r_shift) ^ r_sync2;
                  r_cnt     <= BIT_LOAD;
                  r_state   <= ST_STOP;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
`endif
            ST_STOP: begin
               if (w_tick) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // A pop frees the slot the same cycle, so a push into a full FIFO with a pop is accepted.
   assign w_pop         = read_enable & r_valid;
   assign w_push        = w_frame_ok & (~r_full | w_pop);
   assign w_overrun_set = w_frame_ok & r_full & ~w_pop;

   // Occupancy after this cycle's push/pop.
   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CNT1_ONE;
         2'b01:   w_count_nxt = r_count - CNT1_ONE;
         default: w_count_nxt = r_count;
      endcase
   end

   // FIFO storage; contents need no reset because read_data is masked while empty.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= r_shift;
      end
   end

   // FIFO pointers, occupancy and registered status flags.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {(PTR_W+1){1'b0}};
         r_valid  <= 1'b0;
         r_full   <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         r_count <= w_count_nxt;
         r_valid <= (w_count_nxt != {(PTR_W+1){1'b0}});
         r_full  <= (w_count_nxt == DEPTH_CNT);
      end
   end

   // Sticky error flags; a set in the same cycle wins over clear_errors.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_framing_error <= 1'b0;
         r_overrun_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_error  <= 1'b0;
`endif
      end else begin
         if (w_framing_set) begin
            r_framing_error <= 1'b1;
         end else if (clear_errors) begin
            r_framing_error <= 1'b0;
         end
         if (w_overrun_set) begin
            r_overrun_error <= 1'b1;
         end else if (clear_errors) begin
            r_overrun_error <= 1'b0;
         end
`ifdef UART_RX_PARITY_EN
         if (w_parity_set) begin
            r_parity_error <= 1'b1;
         end else if (clear_errors) begin
            r_parity_error <= 1'b0;
         end
`endif
      end
   end

   // First-word fall-through head.
   always_comb begin
      if (r_valid) begin
         read_data = r_mem[r_rd_ptr];
      end else begin
         read_data = 8'h00;
      end
   end

   assign data_valid    = r_valid;
   assign fifo_full     = r_full;
   assign framing_error = r_framing_error;
   assign overrun_error = r_overrun_error;
`ifdef UART_RX_PARITY_EN
   assign parity_error  = r_parity_error;
`else
   assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed scenarios plus random frames, all checked every cycle
// against a queue-based model of the FIFO and sticky flags driven by frame-completion events.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

   localparam int CLK_HZ = 1000000;
   localparam int BAUD   = 47000;
   localparam int DEPTH  = 8;
   localparam int CPB    = 21;    // 1000000 / 47000, truncated
   localparam int HALF   = 10;
`ifdef UART_RX_PARITY_EN
   localparam int NFB    = 10;    // start + 8 data + parity, stop is bit NFB
   localparam int LAT    = 223;   // 2 + HALF + 10*CPB + 1
`else
   localparam int NFB    = 9;
   localparam int LAT    = 202;   // 2 + HALF + 9*CPB + 1
`endif

   logic       clock         = 1'b0;
   logic       reset_n       = 1'b0;
   logic       uart_rx       = 1'b1;
   logic       read_enable   = 1'b0;
   logic       clear_errors  = 1'b0;
   logic [7:0] read_data;
   logic       data_valid;
   logic       fifo_full;
   logic       framing_error;
   logic       overrun_error;
   logic       parity_error;

   uart_rx_fifo #(
      .CLOCK_FREQUENCY_HZ(CLK_HZ),
      .BAUD_RATE(BAUD),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .uart_rx(uart_rx),
      .read_enable(read_enable),
      .read_data(read_data),
      .data_valid(data_valid),
      .fifo_full(fifo_full),
      .framing_error(framing_error),
      .overrun_error(overrun_error),
      .parity_error(parity_error),
      .clear_errors(clear_errors)
   );

   always #5 clock = ~clock;

   typedef struct {
      int         at;
      logic [7:0] b;
      logic       good;
      logic       fe;
      logic       pe;
   } ev_t;

   ev_t        evq[$];
   logic [7:0] mq[$];
   logic       m_fe = 1'b0;
   logic       m_oe = 1'b0;
   logic       m_pe = 1'b0;
   int         cyc = 0;
   int         last_fall = 0;
   logic       re_s = 1'b0;
   logic       clr_s = 1'b0;
   int         checks = 0;
   int         errors = 0;
   logic       rnd_done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   always @(posedge clock) begin
      cyc   = cyc + 1;
      re_s  = read_enable;
      clr_s = clear_errors;
   end

   // Model update for the edge just passed, then one packed comparison of all outputs.
   always @(negedge clock) begin : model_b
      logic        pop;
      logic        was_full;
      logic        sfe;
      logic        soe;
      logic        spe;
      logic [12:0] exp_v;
      logic [12:0] act_v;
      if (!reset_n) begin
         mq.delete();
         evq.delete();
         m_fe = 1'b0;
         m_oe = 1'b0;
         m_pe = 1'b0;
      end else begin
         pop      = re_s && (mq.size() > 0);
         was_full = (mq.size() == DEPTH);
         sfe = 1'b0;
         soe = 1'b0;
         spe = 1'b0;
         if (pop) void'(mq.pop_front());
         while (evq.size() > 0 && evq[0].at <= cyc) begin
            if (evq[0].at == cyc) begin
               if (evq[0].good) begin
                  if (!was_full || pop) mq.push_back(evq[0].b);
                  else soe = 1'b1;
               end
               sfe = sfe | evq[0].fe;
               spe = spe | evq[0].pe;
            end
            void'(evq.pop_front());
         end
         m_fe = sfe | (m_fe & ~clr_s);
         m_oe = soe | (m_oe & ~clr_s);
         m_pe = spe | (m_pe & ~clr_s);
      end
      exp_v = {mq.size() > 0, mq.size() == DEPTH, m_fe, m_oe, m_pe,
               (mq.size() > 0) ? mq[0] : 8'h00};
      act_v = {data_valid, fifo_full, framing_error, overrun_error, parity_error, read_data};
      chk("outputs{valid,full,fe,oe,pe,data}", {19'd0, act_v}, {19'd0, exp_v});
   end

   // Drives one frame starting just after a rising edge; registers the expected outcome.
   task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
      ev_t         e;
      logic [NFB:0] bits;
      @(posedge clock);
      #1;
      last_fall = cyc;
      e.at = cyc + LAT;
      e.b  = d;
      e.fe = ~stop_b;
`ifdef UART_RX_PARITY_EN
      e.pe   = par_flip;
      e.good = stop_b & ~par_flip;
      bits   = {stop_b, (^d) ^ par_flip, d, 1'b0};
`else
      e.pe   = 1'b0;
      e.good = stop_b;
      bits   = {stop_b, d, 1'b0};
`endif
      evq.push_back(e);
      for (int i = 0; i <= NFB; i++) begin
         uart_rx = bits[i];
         repeat (CPB) @(posedge clock);
         #1;
      end
      uart_rx = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   task automatic do_read(input string name, input logic [7:0] exp);
      chk(name, {23'd0, data_valid, read_data}, {23'd0, 1'b1, exp});
      read_enable = 1'b1;
      @(negedge clock);
      read_enable = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_errors = 1'b1;
      @(negedge clock);
      clear_errors = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int f;
      int lat;
      repeat (3) @(negedge clock);
      chk("reset_state", {26'd0, data_valid, fifo_full, framing_error, overrun_error,
          parity_error, |read_data}, 32'd0);
      #3 reset_n = 1'b1;
      repeat (3) @(negedge clock);

      // 1: latency and single read
      lat = -1;
      fork
         send_frame(8'hA5, 1'b1, 1'b0);
         begin
            @(posedge clock);
            #2;
            f = last_fall;
            for (int k = 0; k < 400; k++) begin
               @(negedge clock);
               if (data_valid) begin
                  lat = cyc - f;
                  break;
               end
            end
         end
      join
      checks++;
      if (lat < LAT - 1 || lat > LAT + 1) begin
         errors++;
         $display("FAIL latency: got %0d cycles expected %0d +/- 1", lat, LAT);
      end
      do_read("t1_data", 8'hA5);
      chk("t1_empty_after_read", {31'd0, data_valid}, 32'd0);
      chk("t1_flags", {29'd0, framing_error, overrun_error, parity_error}, 32'd0);

      // 2: start glitch shorter than half a bit
      @(posedge clock);
      #1 uart_rx = 1'b0;
      repeat (HALF / 2) @(posedge clock);
      #1 uart_rx = 1'b1;
      repeat (3 * CPB) @(negedge clock);
      chk("t2_glitch", {28'd0, data_valid, framing_error, overrun_error, parity_error}, 32'd0);

      // 3: framing error, then good frame, then clear
      send_frame(8'h3C, 1'b0, 1'b0);
      chk("t3_framing_set", {30'd0, framing_error, data_valid}, 32'd2);
      send_frame(8'h11, 1'b1, 1'b0);
      do_read("t3_data", 8'h11);
      pulse_clear();
      chk("t3_framing_cleared", {31'd0, framing_error}, 32'd0);

      // 4: fill, overrun, drain in order
      for (int i = 0; i < 8; i++) send_frame(i[7:0], 1'b1, 1'b0);
      chk("t4_full", {30'd0, fifo_full, overrun_error}, 32'd2);
      send_frame(8'h08, 1'b1, 1'b0);
      chk("t4_overrun", {30'd0, fifo_full, overrun_error}, 32'd3);
      for (int i = 0; i < 8; i++) do_read("t4_drain", i[7:0]);
      chk("t4_empty", {31'd0, data_valid}, 32'd0);
      pulse_clear();

      // 5: push into full FIFO on the same edge as a pop
      for (int i = 0; i < 8; i++) send_frame(8'h40 + i[7:0], 1'b1, 1'b0);
      fork
         send_frame(8'h48, 1'b1, 1'b0);
         begin
            @(posedge clock);
            #2;
            f = last_fall;
            while (cyc < f + LAT - 1) @(negedge clock);
            read_enable = 1'b1;
            @(negedge clock);
            read_enable = 1'b0;
         end
      join
      chk("t5_full_no_overrun", {30'd0, fifo_full, overrun_error}, 32'd2);
      for (int i = 1; i <= 8; i++) do_read("t5_drain", 8'h40 + i[7:0]);
      chk("t5_empty", {31'd0, data_valid}, 32'd0);

      // random frames with a slow random reader and occasional clears
      fork
         begin
            for (int i = 0; i < 12; i++)
               send_frame($urandom_range(0, 255), ($urandom_range(0, 7) != 0), 1'b0);
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               read_enable  = ($urandom_range(0, 255) < 2);
               clear_errors = ($urandom_range(0, 511) == 0);
               @(negedge clock);
            end
            read_enable  = 1'b0;
            clear_errors = 1'b0;
         end
      join
      while (data_valid) do_read("rnd_drain", mq[0]);
      pulse_clear();

      // 6: reset in the middle of a frame
      send_frame(8'h5A, 1'b1, 1'b0);
      send_frame(8'h3C, 1'b0, 1'b0);
      chk("t6_pre_reset", {30'd0, data_valid, framing_error}, 32'd3);
      fork
         send_frame(8'hFF, 1'b1, 1'b0);
         begin
            @(posedge clock);
            #2;
            f = last_fall;
            while (cyc < f + 6 * CPB + 3) @(negedge clock);
            #3 reset_n = 1'b0;
            #1;
            chk("t6_async_reset", {26'd0, data_valid, fifo_full, framing_error,
                overrun_error, parity_error, |read_data}, 32'd0);
            repeat (3) @(negedge clock);
            #3 reset_n = 1'b1;
         end
      join
      chk("t6_no_partial_byte", {31'd0, data_valid}, 32'd0);
      send_frame(8'h81, 1'b1, 1'b0);
      do_read("t6_data", 8'h81);
`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b0);
      do_read("t6_parity_ok", 8'h07);
      send_frame(8'h07, 1'b1, 1'b1);
      chk("t6_parity_bad", {30'd0, parity_error, data_valid}, 32'd2);
`endif

      repeat (4) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
